// File: rtl/fetch_buffer_if.sv
// Fetch-buffer bundle: instruction-memory request/response, redirect, and the decode-side valid/ready pair.
// Handshake: an entry moves to decode on a rising clock edge only when id_valid_o && id_ready_i; while id_ready_i is low the head stays put.
interface fetch_buffer_if;
  logic        start_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_ready_i;

  modport master (
    input  start_i, imem_instr_i, redirect_i, redirect_pc_i, id_ready_i,
    output imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o
  );

  modport slave (
    output start_i, imem_instr_i, redirect_i, redirect_pc_i, id_ready_i,
    input  imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch queue with credit-based request issue and redirect flush.
// Optional macro FETCH_BUFFER_BYPASS_EN presents a response straight to decode when the queue is empty.
module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fetch_buffer_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   tag;
  logic          inflight;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic [CW:0]   used;
  logic [31:0]   redirect_word;
  logic          req;
  logic          resp_live;
  logic          q_valid;
  logic          push;
  logic          pop;
`ifdef FETCH_BUFFER_BYPASS_EN
  logic          bypass;
`endif

  // Credits count both stored entries and the response still on its way, so the queue never overflows.
  always_comb begin
    redirect_word = bus.redirect_pc_i & ~32'h3;
    used          = {1'b0, count} + (CW+1)'(inflight);
    resp_live     = inflight & ~bus.redirect_i;
    q_valid       = (count != '0);
    req           = rst_i & bus.start_i & ~bus.redirect_i & (used < (CW+1)'(DEPTH));
    pop           = q_valid & bus.id_ready_i;
  end

`ifdef FETCH_BUFFER_BYPASS_EN
  always_comb begin
    bypass         = resp_live & ~q_valid;
    push           = resp_live & ~(bypass & bus.id_ready_i);
    bus.id_valid_o = q_valid | bypass;
    bus.id_instr_o = '0;
    bus.id_pc_o    = '0;
    if (q_valid) begin
      bus.id_instr_o = q_instr[head];
      bus.id_pc_o    = q_pc[head];
    end else if (bypass) begin
      bus.id_instr_o = bus.imem_instr_i;
      bus.id_pc_o    = tag;
    end
  end
`else
  always_comb begin
    push           = resp_live;
    bus.id_valid_o = q_valid;
    bus.id_instr_o = '0;
    bus.id_pc_o    = '0;
    if (q_valid) begin
      bus.id_instr_o = q_instr[head];
      bus.id_pc_o    = q_pc[head];
    end
  end
`endif

  always_comb begin
    bus.imem_req_o  = req;
    bus.imem_addr_o = fetch_pc;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= req;
      if (req) tag <= fetch_pc;
      // A redirect still honours the pop handshake of this cycle, then discards everything else.
      if (bus.redirect_i) begin
        fetch_pc <= redirect_word;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (req)  fetch_pc <= fetch_pc + 32'd4;
        if (push) tail     <= tail + PW'(1);
        if (pop)  head     <= head + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_instr[tail] <= bus.imem_instr_i;
      q_pc[tail]    <= tag;
    end
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_i) count <= CW'(DEPTH));
  a_credit: assert property (@(posedge clk_i) disable iff (!rst_i) used <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_fetch_buffer;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef FETCH_BUFFER_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  fetch_buffer_if bus();

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: pcs of entries waiting for decode, plus the one request in the memory pipe.
  logic [31:0] exp_q[$];
  logic        m_inf     = 1'b0;
  logic [31:0] m_inf_pc  = '0;
  logic [31:0] m_pc      = RST_PC;
  logic        resp_pend = 1'b0;
  logic [31:0] resp_addr = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  // Instruction memory: data for last cycle's request, garbage otherwise.
  initial begin
    bus.imem_instr_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_instr_i = resp_pend ? mem_word(resp_addr) : $urandom();
    end
  end

  always @(negedge clk) begin : compare
    int          sz;
    logic        e_req;
    logic        e_byp;
    logic        e_valid;
    logic        took;
    logic [31:0] e_pc;
    sz = exp_q.size();
    if (!rst_n) begin
      exp_q.delete();
      m_inf     = 1'b0;
      m_inf_pc  = '0;
      m_pc      = RST_PC;
      resp_pend = 1'b0;
      chk("rst_req",   bus.imem_req_o,  0);
      chk("rst_addr",  bus.imem_addr_o, RST_PC);
      chk("rst_valid", bus.id_valid_o,  0);
      chk("rst_instr", bus.id_instr_o,  0);
      chk("rst_pc",    bus.id_pc_o,     0);
    end else begin
      e_req   = bus.start_i && !bus.redirect_i && (sz + int'(m_inf) < DEPTH);
      e_byp   = BYP && m_inf && !bus.redirect_i && (sz == 0);
      e_valid = (sz != 0) || e_byp;
      e_pc    = (sz != 0) ? exp_q[0] : m_inf_pc;
      chk("m_req",   bus.imem_req_o,  e_req);
      chk("m_addr",  bus.imem_addr_o, m_pc);
      chk("m_valid", bus.id_valid_o,  e_valid);
      if (e_valid) begin
        chk("m_pc",    bus.id_pc_o,    e_pc);
        chk("m_instr", bus.id_instr_o, mem_word(e_pc));
      end
      resp_pend = bus.imem_req_o;
      resp_addr = bus.imem_addr_o;
      took = e_valid && bus.id_ready_i;
      if (took && sz != 0) void'(exp_q.pop_front());
      if (bus.redirect_i) begin
        exp_q.delete();
        m_inf = 1'b0;
        m_pc  = bus.redirect_pc_i & ~32'h3;
      end else begin
        if (m_inf && !(e_byp && took)) exp_q.push_back(m_inf_pc);
        m_inf    = e_req;
        m_inf_pc = m_pc;
        if (e_req) m_pc = m_pc + 32'd4;
      end
    end
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic r);
    bus.start_i    = s;
    bus.id_ready_i = r;
  endtask

  task automatic reset_pulse();
    tick();
    rst_n          = 1'b0;
    bus.redirect_i = 1'b0;
    drive(1'b0, 1'b0);
    tick();
    tick();
  endtask

  initial begin : main
    int          n;
    int          n8;
    int          nc;
    bit          found;
    logic [31:0] log_q[$];

    rst_n             = 1'b1;
    bus.start_i       = 1'b0;
    bus.id_ready_i    = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    look();
    chk("reset_req",   bus.imem_req_o, 0);
    chk("reset_valid", bus.id_valid_o, 0);
    chk("reset_pc",    bus.id_pc_o,    0);

    // Free-running stream: one instruction per cycle after the pipeline latency.
    reset_pulse();
    rst_n = 1'b1;
    drive(1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      look();
      chk("a_req",   bus.imem_req_o,  1);
      chk("a_addr",  bus.imem_addr_o, 32'(c * 4));
      chk("a_valid", bus.id_valid_o,  (c >= LAT));
      if (c >= LAT) begin
        chk("a_pc",    bus.id_pc_o,    32'((c - LAT) * 4));
        chk("a_instr", bus.id_instr_o, 32'(c - LAT));
      end
      tick();
    end

    // Decode stalled: credits stop issue at DEPTH, head held, then drain and resume.
    reset_pulse();
    rst_n = 1'b1;
    drive(1'b1, 1'b0);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      look();
      n += int'(bus.imem_req_o);
      if (bus.id_valid_o) chk("b_hold_pc", bus.id_pc_o, 0);
      tick();
    end
    chk("b_req_total", n, 4);
    drive(1'b1, 1'b1);
    look();
    chk("b_c8_req",   bus.imem_req_o, 0);
    chk("b_c8_valid", bus.id_valid_o, 1);
    chk("b_c8_pc",    bus.id_pc_o,    32'h0);
    tick();
    look();
    chk("b_c9_req",  bus.imem_req_o,  1);
    chk("b_c9_addr", bus.imem_addr_o, 32'h10);
    chk("b_c9_pc",   bus.id_pc_o,     32'h4);
    tick();
    look();
    chk("b_c10_pc", bus.id_pc_o, 32'h8);
    tick();
    look();
    chk("b_c11_pc", bus.id_pc_o, 32'hC);
    tick();
    look();
    chk("b_c12_valid", bus.id_valid_o, 1);
    chk("b_c12_pc",    bus.id_pc_o,    32'h10);

    // Redirect with three queued entries and one response in flight.
    reset_pulse();
    rst_n = 1'b1;
    drive(1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      look();
      tick();
    end
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h100;
    look();
    chk("c_redir_req", bus.imem_req_o, 0);
    chk("c_redir_pc",  bus.id_pc_o,    32'h0);
    tick();
    bus.redirect_i = 1'b0;
    drive(1'b1, 1'b1);
    for (int c = 5; c < 11; c++) begin
      look();
      if (c == 5) begin
        chk("c_new_req",  bus.imem_req_o,  1);
        chk("c_new_addr", bus.imem_addr_o, 32'h100);
      end
      chk("c_valid", bus.id_valid_o, (c >= 5 + LAT));
      if (c >= 5 + LAT) chk("c_pc", bus.id_pc_o, 32'h100 + 32'((c - 5 - LAT) * 4));
      tick();
    end

    // Redirect in the same cycle that 0x8 is popped; low address bits ignored.
    reset_pulse();
    rst_n = 1'b1;
    drive(1'b1, 1'b0);
    log_q.delete();
    for (int c = 0; c < 2; c++) begin
      look();
      tick();
    end
    drive(1'b1, 1'b1);
    for (int c = 2; c < 4; c++) begin
      look();
      if (bus.id_valid_o && bus.id_ready_i) log_q.push_back(bus.id_pc_o);
      tick();
    end
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h202;
    look();
    chk("d_pop_pc", bus.id_pc_o, 32'h8);
    if (bus.id_valid_o && bus.id_ready_i) log_q.push_back(bus.id_pc_o);
    tick();
    bus.redirect_i = 1'b0;
    for (int c = 5; c < 12; c++) begin
      look();
      if (c == 5) chk("d_new_addr", bus.imem_addr_o, 32'h200);
      if (bus.id_valid_o && bus.id_ready_i) log_q.push_back(bus.id_pc_o);
      tick();
    end
    n8 = 0;
    nc = 0;
    foreach (log_q[k]) begin
      if (log_q[k] == 32'h8) n8++;
      if (log_q[k] == 32'hC) nc++;
    end
    chk("d_8_once",    n8, 1);
    chk("d_c_never",   nc, 0);
    chk("d_first_new", log_q[3], 32'h200);

    // Asynchronous reset with two entries queued and one in flight.
    reset_pulse();
    rst_n = 1'b1;
    drive(1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      look();
      tick();
    end
    #1 rst_n = 1'b0;
    #1;
    chk("e_req",   bus.imem_req_o,  0);
    chk("e_addr",  bus.imem_addr_o, RST_PC);
    chk("e_valid", bus.id_valid_o,  0);
    chk("e_instr", bus.id_instr_o,  0);
    chk("e_pc",    bus.id_pc_o,     0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      look();
      if (bus.id_valid_o) begin
        found = 1'b1;
        chk("e_first_cycle", c, LAT);
        chk("e_first_pc",    bus.id_pc_o,    RST_PC);
        chk("e_first_instr", bus.id_instr_o, mem_word(RST_PC));
      end
      if (found) break;
      tick();
    end
    chk("e_found", found, 1);

    // Random decode stalls, fetch enable and occasional redirects.
    for (int i = 0; i < 10000; i++) begin
      tick();
      drive(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)));
      bus.redirect_i    = ($urandom_range(0, 63) == 0);
      bus.redirect_pc_i = $urandom();
    end
    tick();
    bus.redirect_i = 1'b0;
    drive(1'b0, 1'b1);
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  fetch enable; no new requests while low.
REQ-006 SHALL have port imem_req_o  output  1  instruction-memory read request.
REQ-007 SHALL have port imem_addr_o  output  32  request address, word-aligned.
REQ-008 SHALL have port imem_instr_i  input  32  read data, valid exactly one cycle after imem_req_o.
REQ-009 SHALL have port redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirect_pc_i  input  32  new fetch address, sampled when redirect_i high.
REQ-011 SHALL have port id_valid_o  output  1  head entry valid to decode.
REQ-012 SHALL have port id_instr_o  output  32  head instruction.
REQ-013 SHALL have port id_pc_o  output  32  address of head instruction.
REQ-014 SHALL have port id_ready_i  input  1  decode accepts (low = hazard stall).

Function
REQ-015 SHALL drive imem_addr_o = fetch_pc combinationally; fetch_pc advances by 4 on each issued request.
REQ-016 SHALL assert imem_req_o when start_i high, redirect_i low, and count + inflight < DEPTH (credit rule; queue never overflows).
REQ-017 SHALL capture the request address into an inflight tag and, next cycle, push {tag, imem_instr_i} at tail unless killed.
REQ-018 SHALL pop head when id_valid_o && id_ready_i; push and pop in same cycle SHALL leave count unchanged.
REQ-019 SHALL hold id_instr_o/id_pc_o stable while id_valid_o high and id_ready_i low.
REQ-020 SHALL wrap head/tail pointers modulo DEPTH; count SHALL range 0..DEPTH.
REQ-021 SHALL, on redirect_i, complete any same-cycle pop, then empty queue, kill the in-flight response, and load fetch_pc <= redirect_pc_i; first request at new PC issues the following cycle.
REQ-022 SHALL ignore redirect_pc_i[1:0] (forced to 00).
REQ-023 SHALL drive id_valid_o = (count != 0) (non-bypass build).
REQ-024 SHALL, with start_i low, issue no requests but still accept in-flight response and drain to decode.
REQ-025 Latency (non-bypass): request cycle N -> id_valid_o cycle N+2.

Reset
REQ-026 SHALL, while rst_i low, set fetch_pc=RESET_PC, head=tail=count=0, inflight=0, kill=0, imem_req_o=0, id_valid_o=0, id_instr_o=0, id_pc_o=0.
REQ-027 SHALL discard any in-flight response when reset asserts mid-operation; first request issues on the first clock edge after release with start_i high.

Configuration
REQ-028 Macro FETCH_BUFFER_BYPASS_EN: when defined, an unkilled response arriving while count==0 SHALL appear on id_* in the same cycle (id_valid_o high, latency N+1); if accepted it is not pushed, otherwise it is pushed.
REQ-029 Without FETCH_BUFFER_BYPASS_EN, all responses SHALL be registered in the queue before presentation (latency N+2).

Verification
REQ-030 Reset release, start_i=1, id_ready_i=1, imem returns addr>>2 -> requests at 0,4,8,...; id_pc_o=0 first valid at cycle 2 (cycle 1 with bypass), then one instruction per cycle.
REQ-031 id_ready_i=0 from cycle 0, DEPTH=4 -> exactly 4 requests (0..12), imem_req_o then low; id_pc_o held at 0; releasing ready drains 0,4,8,12 then fetch resumes at 16.
REQ-032 redirect_i=1, redirect_pc_i=32'h100 while queue holds 3 entries and one in flight -> id_valid_o low next cycle, killed response never appears, next request at 0x100, next id_pc_o=0x100.
REQ-033 Redirect in same cycle as a pop of entry 0x8 -> 0x8 counted delivered exactly once; 0xC never delivered.
REQ-034 Random id_ready_i for 10000 cycles, pointer wrap many times -> id_pc_o strictly sequential by 4, no loss/duplication, count never exceeds DEPTH.
REQ-035 rst_i low mid-stream with 2 entries and 1 in flight -> all outputs 0 immediately (async); after release first id_pc_o = RESET_PC.
